// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an rxd synchroniser, false-start rejection, mid-bit sampling and framing-error reporting.
// Optional: define UART_RX_GLITCH_FILTER_EN to insert a 3-tap majority filter that swallows single-cycle glitches.
module uart_rx #(
    parameter int CLK_PER_BIT = 868,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_ready,
    output logic [7:0] rdata,
    output logic       ferr,
    output logic       busy
);

    localparam int            CW         = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT   = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Synchroniser resets to all-ones so the line looks idle straight out of reset.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_reg[SYNC_STAGES-1];

    logic line;

`ifdef UART_RX_GLITCH_FILTER_EN
    // Taps are rxs plus two delayed copies; a lone low (or high) cycle never wins the vote.
    logic [1:0] tap_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            tap_reg <= '1;
        end else begin
            tap_reg <= {tap_reg[0], rxs};
        end
    end

    assign line = (rxs & tap_reg[0]) | (rxs & tap_reg[1]) | (tap_reg[0] & tap_reg[1]);
`else
    assign line = rxs;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic          rx_ready_reg, rx_ready_next;
    logic          ferr_reg, ferr_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            rdata_reg    <= '0;
            rx_ready_reg <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            rdata_reg    <= rdata_next;
            rx_ready_reg <= rx_ready_next;
            ferr_reg     <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        rdata_next    = rdata_reg;
        rx_ready_next = 1'b0;
        ferr_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!line) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end

            // Re-check the start bit at its centre; later samples then land mid-bit.
            START: begin
                if (cnt_reg == HALF_BIT) begin
                    if (line) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = '0;
                        bit_next   = '0;
                        state_next = DATA;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            DATA: begin
                if (cnt_reg == LAST_CYCLE) begin
                    cnt_next   = '0;
                    shift_next = {line, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            // Returning to IDLE right at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
            STOP: begin
                if (cnt_reg == LAST_CYCLE) begin
                    cnt_next = '0;
                    if (line) begin
                        rdata_next    = shift_reg;
                        rx_ready_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            BREAK: begin
                if (line) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_ready = rx_ready_reg;
    assign ferr     = ferr_reg;
    assign rdata    = rdata_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Converts the serial line from the host PC into byte strobes.
- Sits directly upstream of the DMA/program loader, driving its `rx_ready`/`rdata` inputs.
- Provides a 2-FF synchroniser, false-start rejection, mid-bit sampling and framing-error reporting.
- Single clock domain; the only asynchronous input is `rxd`.

Parameters:
- CLK_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud); legal range is ≥ 4.
- SYNC_STAGES, 2, number of flip-flops in the `rxd` synchroniser; legal range is ≥ 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  serial line; idles high; asynchronous.
- rx_ready  output  1  one-cycle pulse: `rdata` holds a newly received valid byte.
- rdata  output  8  last correctly framed byte; stable until the next `rx_ready`.
- ferr  output  1  one-cycle pulse: stop bit sampled low (framing error).
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Clock/reset: clock is `clock`; reset is `reset`, synchronous, active-high.
- Reset values:
  - `rx_ready` = 0, `ferr` = 0, `busy` = 0, `rdata` = 8'h00.
  - Synchroniser flip-flops = 1 (line treated as idle).
  - State = IDLE; bit counter and cycle counter = 0.
- Reset mid-frame: the partial byte is discarded and no pulse is emitted.
- `rxs` is the synchronised line (last synchroniser stage). All decisions use `rxs` only.
- Cycle counter:
  - Width is `$clog2(CLK_PER_BIT)`.
  - Half-bit point is `CLK_PER_BIT/2 - 1`, using integer division.
- States:
  - IDLE: stay while `rxs`=1. When `rxs`=0, clear the cycle counter and go to START.
  - START: count to the half-bit point, then sample `rxs`.
    - `rxs`=1: false start. Return to IDLE with no pulse.
    - `rxs`=0: clear the counter and go to DATA with bit index 0.
  - DATA: every CLK_PER_BIT cycles, sample `rxs` into a shift register, LSB first.
    - After index 7, go to STOP.
  - STOP: after CLK_PER_BIT cycles, sample `rxs`.
    - `rxs`=1: load `rdata` with the shift register and assert `rx_ready` for exactly 1 cycle. Go to IDLE in the same cycle. Back-to-back frames with no extra idle time must be received.
    - `rxs`=0: assert `ferr` for 1 cycle, leave `rdata` unchanged, go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE. A held-low line yields exactly one `ferr` and no spurious frames.
- Timing:
  - `rdata` and `rx_ready` change in the same cycle. `rx_ready` is registered, not combinational.
  - Latency from the `rxd` falling edge to `rx_ready` = `SYNC_STAGES + 1 + CLK_PER_BIT/2 + 9*CLK_PER_BIT` cycles, ±1.
- `rx_ready` and `ferr` are mutually exclusive and never asserted in consecutive cycles.
- No flow control: the consumer must accept each `rx_ready` pulse. There is no buffering.

Optional Feature:
- Macro: UART_RX_GLITCH_FILTER_EN.
- Defined:
  - A 3-tap shift register follows the synchroniser.
  - The line used by the FSM is the majority of the 3 taps.
  - Single-cycle glitches on `rxd` are ignored in every state.
  - All latencies increase by 1 cycle.
- Undefined: the FSM uses `rxs` directly. A 1-cycle low pulse in IDLE enters START and is rejected at the half-bit check as a false start.

Test Plan (CLK_PER_BIT=16, SYNC_STAGES=2):
- Single frame 0x99: expect one `rx_ready` pulse with `rdata`=8'h99 between 154 and 156 cycles after the falling edge. `ferr` stays 0. `busy` is high during the frame.
- Back-to-back frames 0x04,0x00,0x00,0x00 with no gap: expect 4 `rx_ready` pulses spaced 160 cycles apart, carrying `rdata` 04,00,00,00 in order.
- Frame 0x5A with stop bit forced low, then line held low for 400 cycles, then released, then frame 0x3C:
  - First frame: one `ferr` pulse, no `rx_ready`, `rdata` keeps its prior value.
  - Second frame: `rx_ready` with `rdata`=8'h3C.
- Low pulse of 4 cycles on an idle line: no `rx_ready`, no `ferr`, and `busy` is 0 within 12 cycles.
  - With UART_RX_GLITCH_FILTER_EN: a 1-cycle pulse never sets `busy`.
- Assert reset for 1 cycle during bit 3 of frame 0xFF: no pulse is emitted for that frame. All outputs are at reset values the cycle after reset. A subsequent clean frame 0xA5 yields `rx_ready` with `rdata`=8'hA5.
